// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer that owns the PC and feeds decode through a one-entry output slot.
// Latency: one cycle from the PC on imem_addr to out_valid; a redirect costs exactly one bubble.
// Backpressure: while out_valid && !out_ready the slot and the PC hold; a redirect squashes the slot.
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   start             - one-cycle pulse, leaves IDLE and begins fetching
//   imem_addr         - byte address to instruction memory (always the PC)
//   imem_instr        - instruction word returned combinationally for imem_addr
//   out_valid/ready   - handshake to decode; out_pc/out_instr carry the fetched word
//   redirect_valid    - taken branch/jump; redirect_target is the next PC (bits [1:0] dropped)
//   halted            - high while in HALTED
//   fetch_count       - saturating count of completed handshakes
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_out_valid;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;
  logic        r_halted;
  logic [15:0] r_fetch_count;

  logic        w_handshake;
  logic        w_slot_free;
  logic        w_at_limit;
  logic [31:0] w_redir_pc;

  assign w_handshake = r_out_valid && out_ready;
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_at_limit  = (r_pc >= LIMIT);
  assign w_redir_pc  = redirect_target & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_out_valid   <= 1'b0;
      r_out_pc      <= 32'h0;
      r_out_instr   <= 32'h0;
      r_halted      <= 1'b0;
      r_fetch_count <= 16'h0;
    end else begin
      // Handshakes count in every state, including the cycle of a redirect.
      if (w_handshake && (r_fetch_count != 16'hFFFF)) begin
        r_fetch_count <= r_fetch_count + 16'd1;
      end

      // Default drain of the slot; a load below overrides this.
      if (w_handshake) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (redirect_valid) begin
            r_pc <= w_redir_pc;
          end
          if (start) begin
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (redirect_valid) begin
            // Squash whatever sits in the slot; the target is fetched next cycle.
            r_pc        <= w_redir_pc;
            r_out_valid <= 1'b0;
          end else if (w_at_limit) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else if (w_slot_free) begin
            r_out_pc    <= r_pc;
            r_out_instr <= imem_instr;
            r_out_valid <= 1'b1;
            r_pc        <= r_pc + 32'd4;
          end
        end

        S_HALTED: begin
          if (redirect_valid) begin
            r_pc        <= w_redir_pc;
            r_out_valid <= 1'b0;
            r_state     <= S_RUN;
            r_halted    <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_instr   = r_out_instr;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized and directed bench for fetch_ctrl with a transaction scoreboard.
// Latency: n/a (bench).
// Backpressure: drives out_ready randomly and in directed stall windows.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halted;
  logic [15:0] fetch_count;

  always #5 clk = ~clk;

  logic [31:0] mem [0:31];
  assign imem_instr = mem[imem_addr[6:2]];

  fetch_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state 0=IDLE 1=RUN 2=HALTED, the PC, and what decode should see.
  int          m_st;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_spc;
  logic [31:0] m_sins;
  int          m_count;
  logic [63:0] expq[$];
  bit          mon_en = 1'b0;
  logic [63:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    m_st    = 0;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_spc   = 32'h0;
    m_sins  = 32'h0;
    m_count = 0;
    expq.delete();
  endfunction

  // One clock of the fetch rules, using the inputs driven during that cycle.
  function automatic void model_step();
    bit          hs   = m_valid && out_ready;
    bit          free = !m_valid || out_ready;
    logic [31:0] tgt  = {redirect_target[31:2], 2'b00};
    if (hs && m_count < 65535) m_count++;
    if (hs) m_valid = 1'b0;
    if (m_st == 0) begin
      if (redirect_valid) m_pc = tgt;
      if (start) m_st = 1;
    end else if (m_st == 1) begin
      if (redirect_valid) begin
        m_pc = tgt;
        m_valid = 1'b0;
      end else if (m_pc >= 32'd128) begin
        m_st = 2;
      end else if (free) begin
        m_spc   = m_pc;
        m_sins  = mem[m_pc / 4];
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end else begin
      if (redirect_valid) begin
        m_pc = tgt;
        m_valid = 1'b0;
        m_st = 1;
      end
    end
  endfunction

  // Advance one clock, then drive this cycle's inputs and log any handshake it will produce.
  task automatic cyc(input bit st, input bit rdy, input bit rv, input logic [31:0] tg);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    start           = st;
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = tg;
    if (rst_n && m_valid && rdy) expq.push_back({m_spc, m_sins});
  endtask

  // Monitor: compares visible state every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", out_valid, m_valid);
      chk("halted", halted, m_st == 2);
      chk("fetch_count", fetch_count, m_count);
      if (m_valid) begin
        chk("slot_pc", out_pc, m_spc);
        chk("slot_instr", out_instr, m_sins);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL hs_unexpected actual pc=%0h required=no handshake", out_pc);
        end else begin
          mon_e = expq.pop_front();
          chk("hs_pc", out_pc, mon_e[63:32]);
          chk("hs_instr", out_instr, mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;

    // Lab program in words 0..10, NOPs in 11..15, random filler above.
    mem[0]  = 32'h8C08_0000; mem[1]  = 32'h8C09_0004; mem[2]  = 32'h0109_5020;
    mem[3]  = 32'hAC0A_0008; mem[4]  = 32'h0109_5822; mem[5]  = 32'h0109_6024;
    mem[6]  = 32'h0109_6825; mem[7]  = 32'h0109_702A; mem[8]  = 32'h1108_0002;
    mem[9]  = 32'h0800_0000; mem[10] = 32'h2008_0005;
    for (int i = 11; i < 16; i++) mem[i] = 32'h0;
    for (int i = 16; i < 32; i++) mem[i] = $urandom;
    model_reset();

    // Reset values while held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fetch_count", fetch_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Idle with no start
    repeat (10) cyc(0, 0, 0, 32'h0);

    // Streaming to the end of memory
    cyc(1, 1, 0, 32'h0);
    repeat (40) cyc(0, 1, 0, 32'h0);
    chk("stream_count", fetch_count, 32);
    chk("stream_halted", halted, 1);

    // Redirect out of HALTED, target low bits dropped
    cyc(0, 1, 1, 32'h0000_000E);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);
    chk("halt_redir_run", halted, 0);
    chk("halt_redir_pc", out_pc, 32'h0C);

    // Backpressure on 0x08
    cyc(0, 1, 1, 32'h08);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);
    chk("bp_addr", imem_addr, 32'h0C);
    chk("bp_pc", out_pc, 32'h08);
    repeat (2) cyc(0, 0, 0, 32'h0);
    chk("bp_addr_hold", imem_addr, 32'h0C);
    chk("bp_pc_hold", out_pc, 32'h08);
    chk("bp_instr_hold", out_instr, mem[2]);
    repeat (5) cyc(0, 1, 0, 32'h0);

    // Redirect in the same cycle as the 0x20 handshake
    cyc(0, 1, 1, 32'h10);
    n = 0;
    while (!(m_valid && m_spc == 32'h20) && n < 100) begin
      cyc(0, 1, 0, 32'h0);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_pc20 actual=timeout required=out_pc 20");
    end
    cyc(0, 1, 1, 32'h0C);
    cyc(0, 1, 0, 32'h0);
    chk("redir_bubble", out_valid, 0);
    cyc(0, 1, 0, 32'h0);
    chk("redir_target_pc", out_pc, 32'h0C);

    // Async reset while stalled with a valid slot
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_imem_addr", imem_addr, 0);
    chk("arst_halted", halted, 0);
    chk("arst_fetch_count", fetch_count, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Redirect in IDLE moves the PC without fetching
    cyc(0, 0, 1, 32'h40);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);
    chk("idle_redir_addr", imem_addr, 32'h40);
    chk("idle_redir_valid", out_valid, 0);
    cyc(1, 1, 0, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 19) == 0, 32'($urandom_range(0, 32'hA0)));
    end
    cyc(0, 1, 0, 32'h0);
    @(negedge clk);
    #1;
    chk("scoreboard_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
